// File: rtl/log_antilog_mult.sv
// -----------------------------------------------------------------------------
// log_antilog_mult
//   Multiplies two operands that arrive in the log2 domain. The two logs are
//   added, and the sum is converted back to the linear domain with a Mitchell
//   antilog (1.frac shifted by the integer part). The pipeline has three
//   register stages:
//     S1 add          : log sum, product sign, zero flag
//     S2 shift        : antilog magnitude, overflow detect
//     S3 sign / range : two's-complement result, zero forcing, range handling
//   A single advance enable (!out_valid | out_ready) moves every stage at once.
//   When it is low, all stages hold, including their valid bits.
//
//   Build option:
//     LOG_ANTILOG_SAT_EN  defined   -> overflowing results saturate to +/-(2^(W-1)-1)
//                         undefined -> overflowing results wrap (low WIDTH bits)
//     out_ovf is reported the same way in both builds.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   a_log      in   [LOG_WIDTH] signed Q5.12 log2|A|
//   b_log      in   [LOG_WIDTH] signed Q5.12 log2|B|
//   a_sign     in   sign of A (1 = negative)
//   b_sign     in   sign of B (1 = negative)
//   a_nz       in   A is non-zero (0 -> A == 0, a_log ignored)
//   b_nz       in   B is non-zero (0 -> B == 0, b_log ignored)
//   in_valid   in   operand pair presented
//   in_ready   out  pair accepted this cycle
//   out_data   out  [WIDTH] signed product, Q(WIDTH-QP).QP
//   out_ovf    out  product magnitude exceeded output range
//   out_valid  out  out_data / out_ovf valid
//   out_ready  in   downstream accepts the result
// -----------------------------------------------------------------------------
module log_antilog_mult #(
    parameter int LOG_WIDTH = 17,
    parameter int WIDTH     = 16,
    parameter int QP        = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LOG_WIDTH-1:0] a_log,
    input  logic [LOG_WIDTH-1:0] b_log,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic                 a_nz,
    input  logic                 b_nz,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // The log fraction is always 12 bits wide. The sum gets one extra bit so
    // that adding two extreme logs cannot wrap.
    localparam int FRAC_W = 12;
    localparam int SUM_W  = LOG_WIDTH + 1;
    localparam int EXP_W  = SUM_W - FRAC_W;

    // The smallest exponent that pushes the leading one into the sign bit.
    localparam logic signed [EXP_W-1:0] OVF_E = EXP_W'(WIDTH - 1 - QP);

`ifdef LOG_ANTILOG_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
`endif

    logic adv;

    logic             s1_valid;
    logic [SUM_W-1:0] s1_sum;
    logic             s1_psign;
    logic             s1_pzero;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_mag;
    logic             s2_psign;
    logic             s2_pzero;
    logic             s2_ovf;

    logic [EXP_W-1:0] exp_c;
    logic [EXP_W-1:0] exp_neg_c;
    logic [WIDTH-1:0] mant_c;
    logic [WIDTH-1:0] mag_c;
    logic             ovf_c;

    logic [WIDTH-1:0] signed_c;
    logic [WIDTH-1:0] res_c;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // S1: log-domain add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_psign <= 1'b0;
            s1_pzero <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sum   <= {a_log[LOG_WIDTH-1], a_log} + {b_log[LOG_WIDTH-1], b_log};
            s1_psign <= a_sign ^ b_sign;
            s1_pzero <= !a_nz | !b_nz;
        end
    end

    // S2: Mitchell antilog. The magnitude only needs WIDTH bits. Bits shifted
    // above WIDTH are either discarded by the wrap or replaced by saturation.
    // A right shift of 13 or more clears the 13-bit mantissa by itself.
    always_comb begin
        exp_c     = s1_sum[SUM_W-1:FRAC_W];
        exp_neg_c = -exp_c;
        mant_c    = WIDTH'({1'b1, s1_sum[FRAC_W-1:0]});
        mag_c     = '0;
        if (exp_c[EXP_W-1]) begin
            mag_c = mant_c >> exp_neg_c;
        end else begin
            mag_c = mant_c << exp_c;
        end
        ovf_c = ($signed(exp_c) >= OVF_E) & !s1_pzero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mag   <= '0;
            s2_psign <= 1'b0;
            s2_pzero <= 1'b0;
            s2_ovf   <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_mag   <= mag_c;
            s2_psign <= s1_psign;
            s2_pzero <= s1_pzero;
            s2_ovf   <= ovf_c;
        end
    end

    // S3: apply the sign and handle the range. Negating a zero magnitude gives
    // 0, so an underflow with a negative sign still outputs 0.
    always_comb begin
        signed_c = s2_psign ? (~s2_mag + 1'b1) : s2_mag;
        res_c    = signed_c;
        if (s2_pzero) begin
            res_c = '0;
        end else if (s2_ovf) begin
`ifdef LOG_ANTILOG_SAT_EN
            res_c = s2_psign ? SAT_NEG : SAT_POS;
`else
            res_c = signed_c;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_data  <= res_c;
            out_ovf   <= s2_ovf;
        end
    end

endmodule
